// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock frequency monitor.
// Holds the FSM encoding and the default measurement parameters.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_GATE
  } state_e;

  localparam int unsigned WARMUP_LEN      = 3;
  localparam int unsigned DEF_GATE_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_EXP_MIN     = 248;
  localparam int unsigned DEF_EXP_MAX     = 252;
  localparam int unsigned DEF_LOST_CYCLES = 64;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector.
// rise is a one-cycle pulse when the synchronized input goes 0 -> 1.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  // [0],[1]: synchronizer stages, [2]: previous synchronized value
  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts sig_in rising edges per gate window of clk cycles and
// reports the count plus in-range and stopped-clock status.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned EXP_MIN     = DEF_EXP_MIN,
  parameter int unsigned EXP_MAX     = DEF_EXP_MAX,
  parameter int unsigned LOST_CYCLES = DEF_LOST_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             freq_ok,
  output logic             freq_lost
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned LOST_W = $clog2(LOST_CYCLES + 1);
  localparam int unsigned WARM_W = $clog2(WARMUP_LEN);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_LIM  = LOST_W'(LOST_CYCLES);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic rise;

  sync_edge_det u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .rise  (rise)
  );

  state_e            state_q, state_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [LOST_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0]  freq_count_q, freq_count_d;
  logic              valid_q, valid_d;
  logic              ok_q, ok_d;
  logic              lost_q, lost_d;

  logic [CNT_W-1:0]  win_total;
  logic              in_range;

  // The edge on the terminal cycle belongs to the closing window
  always_comb begin
    win_total = (edge_q == CNT_MAX) ? CNT_MAX
                                    : edge_q + CNT_W'(rise);
    in_range  = (32'(win_total) >= EXP_MIN) &&
                (32'(win_total) <= EXP_MAX);
  end

  always_comb begin
    state_d      = state_q;
    warm_d       = warm_q;
    gate_d       = gate_q;
    edge_d       = edge_q;
    idle_d       = idle_q;
    freq_count_d = freq_count_q;
    valid_d      = 1'b0;
    ok_d         = ok_q;
    lost_d       = lost_q;

    unique case (state_q)
      ST_IDLE: begin
        warm_d = '0;
        gate_d = '0;
        edge_d = '0;
        idle_d = '0;
        ok_d   = 1'b0;
        lost_d = 1'b0;
        if (en) begin
          state_d = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        warm_d = warm_q + WARM_W'(1);
        if (warm_q == WARM_LAST) begin
          warm_d  = '0;
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        if (gate_q == GATE_LAST) begin
          gate_d       = '0;
          edge_d       = '0;
          freq_count_d = win_total;
          valid_d      = 1'b1;
          ok_d         = in_range;
        end else begin
          gate_d = gate_q + GATE_W'(1);
          edge_d = win_total;
        end
        if (rise) begin
          idle_d = '0;
        end else if (idle_q != LOST_LIM) begin
          idle_d = idle_q + LOST_W'(1);
        end
        lost_d = (idle_d == LOST_LIM);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disable wins over everything, including a terminal cycle
    if (!en) begin
      state_d      = ST_IDLE;
      warm_d       = '0;
      gate_d       = '0;
      edge_d       = '0;
      idle_d       = '0;
      freq_count_d = freq_count_q;
      valid_d      = 1'b0;
      ok_d         = 1'b0;
      lost_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      warm_q       <= '0;
      gate_q       <= '0;
      edge_q       <= '0;
      idle_q       <= '0;
      freq_count_q <= '0;
      valid_q      <= 1'b0;
      ok_q         <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      gate_q       <= gate_d;
      edge_q       <= edge_d;
      idle_q       <= idle_d;
      freq_count_q <= freq_count_d;
      valid_q      <= valid_d;
      ok_q         <= ok_d;
      lost_q       <= lost_d;
    end
  end

  assign freq_count  = freq_count_q;
  assign count_valid = valid_q;
  assign freq_ok     = ok_q;
  assign freq_lost   = lost_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Randomized bench for clk_freq_monitor against a window/edge-time model.
// A second instance with a 4-bit counter covers saturation.
module tb_clk_freq_monitor;

  localparam int G    = 1000;
  localparam int LOST = 64;
  localparam int EMIN = 248;
  localparam int EMAX = 252;

  logic clk = 1'b0;
  logic reset, en, sig_in;
  logic [15:0] fc;
  logic cv, ok, lost;
  logic [3:0] fc4;
  logic cv4, ok4, lost4;

  always #5 clk = ~clk;

  clk_freq_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sig_in      (sig_in),
    .freq_count  (fc),
    .count_valid (cv),
    .freq_ok     (ok),
    .freq_lost   (lost)
  );

  clk_freq_monitor #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sig_in      (sig_in),
    .freq_count  (fc4),
    .count_valid (cv4),
    .freq_ok     (ok4),
    .freq_lost   (lost4)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = 0;
  int phase = 0;
  int hold = 0;
  int run_k = 0;
  bit running = 0;
  bit rise_at [0:65535];

  logic        e_cv, e_ok, e_lost, e_ok4;
  logic [15:0] e_fc;
  logic [3:0]  e_fc4;

  // Rises driven after posedge n are counted in gate cycle n-k-2
  function automatic int win_rises(int k, int w);
    int n0 = k + 2 + w * G;
    int s = 0;
    for (int n = n0; n < n0 + G; n++) s += int'(rise_at[n]);
    return s;
  endfunction

  // Lost when the last LOST gate cycles all exist and hold no edge
  function automatic bit lost_model(int k, int c);
    int gl = c - k - 5;
    if (gl < LOST - 1) return 1'b0;
    for (int j = 0; j < LOST; j++)
      if (rise_at[gl - j + k + 2]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic advance();
    logic nv;
    int n;
    case (mode)
      1: nv = phase[1];
      2: nv = ~sig_in;
      3: begin
        if (hold == 0) begin
          nv = ~sig_in;
          hold = $urandom_range(0, 2);
        end else begin
          nv = sig_in;
          hold--;
        end
      end
      default: nv = 1'b0;
    endcase
    if (nv && !sig_in) rise_at[cyc] = 1'b1;
    sig_in = nv;
    phase++;
    @(posedge clk);
    #1;
    cyc++;
    e_cv = 1'b0;
    if (running) begin
      if (cyc >= run_k + 4 + G && (cyc - run_k - 4) % G == 0) begin
        n = win_rises(run_k, (cyc - run_k - 4 - G) / G);
        e_cv  = 1'b1;
        e_fc  = 16'(n);
        e_fc4 = (n > 15) ? 4'd15 : 4'(n);
        e_ok  = (n >= EMIN && n <= EMAX);
        e_ok4 = (int'(e_fc4) >= EMIN && int'(e_fc4) <= EMAX);
      end
      e_lost = lost_model(run_k, cyc);
    end
  endtask

  task automatic start_run();
    en = 1'b1;
    run_k = cyc;
    running = 1'b1;
  endtask

  task automatic stop_run();
    en = 1'b0;
    running = 1'b0;
    e_ok = 1'b0;
    e_ok4 = 1'b0;
    e_lost = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b0;
    sig_in = 1'b0;
    e_cv = 0; e_ok = 0; e_lost = 0; e_ok4 = 0;
    e_fc = '0; e_fc4 = '0;
    repeat (3) advance();
    checks++;
    if ({cv, ok, lost, fc, cv4, ok4, lost4, fc4} !== '0) begin
      errors++;
      $display("FAIL reset: got %h/%h exp all zero",
               {cv, ok, lost, fc}, {cv4, ok4, lost4, fc4});
    end
    reset = 1'b1;
    repeat (5) advance();
  endtask

  task automatic run_checked(string nm, int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      advance();
      checks++;
      if ({cv, ok, lost, fc} !== {e_cv, e_ok, e_lost, e_fc}) begin
        errors++;
        $display("FAIL %s c=%0d got v/ok/lost/cnt=%b/%b/%b/%0d exp %b/%b/%b/%0d",
                 nm, cyc, cv, ok, lost, fc, e_cv, e_ok, e_lost, e_fc);
      end
      checks++;
      if ({cv4, ok4, lost4, fc4} !== {e_cv, e_ok4, e_lost, e_fc4}) begin
        errors++;
        $display("FAIL %s_w4 c=%0d got v/ok/lost/cnt=%b/%b/%b/%0d exp %b/%b/%b/%0d",
                 nm, cyc, cv4, ok4, lost4, fc4, e_cv, e_ok4, e_lost, e_fc4);
      end
    end
  endtask

  task automatic test_nominal();
    int nv = 0;
    mode = 1;
    repeat (10) advance();
    start_run();
    for (int i = 0; i < 3 * G + 10; i++) begin
      run_checked("nominal", 1);
      if (cv) begin
        nv++;
        checks++;
        if (fc < 249 || fc > 251 || ok !== 1'b1 || lost !== 1'b0) begin
          errors++;
          $display("FAIL nominal_range got cnt=%0d ok=%b lost=%b exp 249..251/1/0",
                   fc, ok, lost);
        end
        checks++;
        if (fc4 !== 4'd15 || ok4 !== 1'b0) begin
          errors++;
          $display("FAIL saturate got cnt=%0d ok=%b exp 15/0", fc4, ok4);
        end
      end
    end
    checks++;
    if (nv != 3) begin
      errors++;
      $display("FAIL nominal_windows got %0d exp 3", nv);
    end
    stop_run();
    run_checked("nominal_stop", 5);
  endtask

  task automatic test_lost();
    int k;
    mode = 0;
    run_checked("lost_pre", 10);
    start_run();
    k = run_k;
    for (int i = 0; i < 2 * G + 10; i++) begin
      run_checked("lost", 1);
      if (cyc == k + 67 || cyc == k + 68) begin
        checks++;
        if (lost !== (cyc == k + 68)) begin
          errors++;
          $display("FAIL lost_onset c=%0d got %b exp %b", cyc - k, lost, cyc == k + 68);
        end
      end
      if (cv) begin
        checks++;
        if (fc !== 16'd0 || ok !== 1'b0) begin
          errors++;
          $display("FAIL lost_count got %0d ok=%b exp 0/0", fc, ok);
        end
      end
    end
    stop_run();
    run_checked("lost_stop", 5);
  endtask

  task automatic test_fast();
    mode = 2;
    run_checked("fast_pre", 10);
    start_run();
    for (int i = 0; i < 2 * G + 10; i++) begin
      run_checked("fast", 1);
      if (cv) begin
        checks++;
        if (fc < 499 || fc > 501 || ok !== 1'b0) begin
          errors++;
          $display("FAIL fast got cnt=%0d ok=%b exp ~500/0", fc, ok);
        end
      end
    end
    stop_run();
    run_checked("fast_stop", 5);
  endtask

  task automatic test_en_drop();
    int k;
    bit seen;
    mode = 1;
    run_checked("drop_pre", 10);
    start_run();
    k = run_k;
    while (cyc < k + 4 + 500) run_checked("drop_a", 1);
    stop_run();
    run_checked("drop_idle", 700);
    start_run();
    k = run_k;
    seen = 0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      run_checked("drop_b", 1);
      if (cv) seen = 1;
    end
    checks++;
    if (!seen || cyc - (k + 1) != 1003) begin
      errors++;
      $display("FAIL drop_latency got seen=%b lat=%0d exp 1003", seen, cyc - (k + 1));
    end
    stop_run();
    run_checked("drop_stop", 5);
  endtask

  task automatic test_random();
    mode = 3;
    run_checked("rand_pre", 10);
    start_run();
    run_checked("random", 4 * G + 10);
    stop_run();
    run_checked("rand_stop", 5);
  endtask

  task automatic test_reset_mid();
    mode = 1;
    start_run();
    run_checked("mid_pre", 1400);
    #2;
    reset = 1'b0;
    sig_in = 1'b0;
    #1;
    checks++;
    if ({cv, ok, lost, fc, cv4, ok4, lost4, fc4} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%h exp all zero",
               {cv, ok, lost, fc}, {cv4, ok4, lost4, fc4});
    end
    stop_run();
    e_fc = '0;
    e_fc4 = '0;
    mode = 0;
    run_checked("mid_rst", 3);
    reset = 1'b1;
    run_checked("mid_idle", 10);
    mode = 1;
    run_checked("mid_pre2", 10);
    start_run();
    run_checked("mid_resume", G + 10);
    stop_run();
    run_checked("mid_stop", 5);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lost();
    test_fast();
    test_en_drop();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
